bh_bank_driver: RTL

- Command-side driver for a bank of W BH flip-flops.
- BH flip-flop encoding: BH=00 complement, 01 set to 1, 10 set to 0, 11 hold. Initial Q=1.
- Accepts a target word over a valid/ready handshake and issues one BH command vector to the bank.
- Reads back the bank's Q outputs, checks them against the target, and retries a bounded number of times before flagging an error.

---
 rtl/bh_bank_driver.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/bh_bank_driver.sv
// bh_bank_driver
//   Command-side driver for a bank of W BH flip-flops. A target word is
//   accepted over a valid/ready handshake. One BH command vector is issued
//   to the bank, and the bank's Q outputs are read back and compared with
//   the target. On a mismatch the command is re-issued, up to MAX_RETRY
//   times, before an error pulse is raised.
//
//   BH encoding per bit: 00 complement, 01 set to 1, 10 set to 0, 11 hold.
//   The bank starts with Q = all 1.
//
//   Optional build macro: BH_TOGGLE_EN
//     When defined, every differing bit is driven with the complement
//     command (00). When undefined, only explicit set/clear commands are
//     used, and 00 is never driven.
//
// Ports
//   clk        system clock; all state changes on the rising edge
//   rst        synchronous active-high reset
//   tgt_data   target Q value for the bank
//   tgt_valid  tgt_data is valid
//   tgt_ready  block can accept a target (only in IDLE)
//   q_fb       Q outputs fed back from the bank
//   B, H       registered per-bit BH command to the bank
//   busy       a transaction is in progress
//   done       one-cycle pulse: target reached
//   err        one-cycle pulse: retries exhausted
//   retry_cnt  retries used by the current or last transaction

module bh_bank_driver #(
  parameter int W         = 4,
  parameter int MAX_RETRY = 2,
  parameter int RETRY_W   = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [W-1:0]       tgt_data,
  input  logic               tgt_valid,
  output logic               tgt_ready,
  input  logic [W-1:0]       q_fb,
  output logic [W-1:0]       B,
  output logic [W-1:0]       H,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [RETRY_W-1:0] retry_cnt
);

  localparam logic [RETRY_W-1:0] MAX_RC = RETRY_W'(MAX_RETRY);
  localparam logic [W-1:0]       ALL1   = {W{1'b1}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    APPLY = 2'd1,
    CHECK = 2'd2
  } state_t;

  state_t             state, state_nxt;
  logic [W-1:0]       target, target_nxt;
  logic [W-1:0]       shadow, shadow_nxt;
  logic [W-1:0]       b_nxt, h_nxt;
  logic               done_nxt, err_nxt;
  logic [RETRY_W-1:0] retry_nxt;

  // Builds the BH command that moves the bank from cur to tgt. Bits that
  // already agree are held. The result is packed as {B, H}.
  function automatic logic [2*W-1:0] bh_cmd(input logic [W-1:0] cur,
                                            input logic [W-1:0] tgt);
    logic [W-1:0] diff;
    diff = cur ^ tgt;
`ifdef BH_TOGGLE_EN
    return {~diff, ~diff};
`else
    return {~(diff & tgt), ~(diff & ~tgt)};
`endif
  endfunction

  assign tgt_ready = (state == IDLE);
  assign busy      = (state != IDLE);

  // State register for the IDLE -> APPLY -> CHECK handshake sequence.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Datapath registers. Reset sets the shadow to all 1 so that it agrees
  // with the bank's power-up value. Reset also drops any in-flight
  // transaction without producing a done or err pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      target    <= '0;
      shadow    <= ALL1;
      B         <= ALL1;
      H         <= ALL1;
      done      <= 1'b0;
      err       <= 1'b0;
      retry_cnt <= '0;
    end else begin
      target    <= target_nxt;
      shadow    <= shadow_nxt;
      B         <= b_nxt;
      H         <= h_nxt;
      done      <= done_nxt;
      err       <= err_nxt;
      retry_cnt <= retry_nxt;
    end
  end

  // Next-state and next-register logic. B/H default to hold, so the
  // command is present only for the single APPLY cycle that follows an
  // accept or a retry. The shadow assumes success when APPLY completes.
  // If CHECK then sees a mismatch, the shadow is replaced with the real
  // bank value, and any retry command is computed from that value.
  always_comb begin
    state_nxt  = state;
    target_nxt = target;
    shadow_nxt = shadow;
    b_nxt      = ALL1;
    h_nxt      = ALL1;
    done_nxt   = 1'b0;
    err_nxt    = 1'b0;
    retry_nxt  = retry_cnt;
    case (state)
      IDLE: begin
        if (tgt_valid) begin
          target_nxt     = tgt_data;
          retry_nxt      = '0;
          {b_nxt, h_nxt} = bh_cmd(shadow, tgt_data);
          state_nxt      = APPLY;
        end
      end
      APPLY: begin
        shadow_nxt = target;
        state_nxt  = CHECK;
      end
      CHECK: begin
        if (q_fb == target) begin
          done_nxt  = 1'b1;
          state_nxt = IDLE;
        end else if (retry_cnt < MAX_RC) begin
          retry_nxt      = retry_cnt + RETRY_W'(1);
          shadow_nxt     = q_fb;
          {b_nxt, h_nxt} = bh_cmd(q_fb, target);
          state_nxt      = APPLY;
        end else begin
          err_nxt    = 1'b1;
          shadow_nxt = q_fb;
          state_nxt  = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule
